// File: rtl/wb_cmd_initiator_if.sv
// wb_cmd_initiator_if: request/response command channel plus Wishbone classic master bus and status.
//   master modport (the initiator): takes req_*, rsp_ready, wbm_ack_i, wbm_dat_i;
//     drives req_ready, rsp_valid/dat/err, wbm_cyc/stb/we/sel/adr/dat_o, busy, txn_count, err_count.
//   slave modport: the opposite directions, for the command source and Wishbone target side.
interface wb_cmd_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    modport master (
        input  req_valid, req_we, req_adr, req_dat, req_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
        output req_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output busy, txn_count, err_count
    );

    modport slave (
        output req_valid, req_we, req_adr, req_dat, req_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
        input  req_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  busy, txn_count, err_count
    );
endinterface

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: single-outstanding Wishbone classic initiator with ack timeout.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : wb_cmd_initiator_if.master -- valid/ready command in, valid/ready response out,
//           Wishbone cyc/stb/we/sel/adr/dat out, ack/dat in, busy and txn/err counters out.
module wb_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 8
) (
    input logic                 clk,
    input logic                 reset,
    wb_cmd_initiator_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_ack;
    logic                   w_tmo;
    logic                   w_rsp_done;
    logic                   r_cyc;
    logic                   r_we;
    logic [3:0]             r_sel;
    logic [31:0]            r_adr;
    logic [31:0]            r_dat;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [31:0]            r_rsp_dat;
    logic                   r_rsp_err;
    logic [15:0]            r_txn;
    logic [7:0]             r_err;

    // Ack is only honoured in ACTIVE; a registered-ack slave's stale ack lands in RESP and is ignored.
    always_comb begin
        w_accept   = r_state == IDLE && bus.req_valid;
        w_ack      = r_state == ACTIVE && bus.wbm_ack_i;
        w_tmo      = r_state == ACTIVE && !bus.wbm_ack_i && r_timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
        w_rsp_done = r_state == RESP && bus.rsp_ready;
        w_next     = w_accept ? ACTIVE : (w_ack || w_tmo) ? RESP : w_rsp_done ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_timer   <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_txn     <= '0;
            r_err     <= '0;
        end else begin
            if (w_accept) begin
                r_cyc   <= 1'b1;
                r_we    <= bus.req_we;
                r_sel   <= bus.req_we ? bus.req_sel : 4'hF;
                r_adr   <= bus.req_adr;
                r_dat   <= bus.req_dat;
                r_timer <= '0;
            end
            if (w_ack) begin
                r_rsp_dat <= r_we ? 32'd0 : bus.wbm_dat_i;
                r_rsp_err <= 1'b0;
                r_txn     <= r_txn + 16'd1;
            end
            if (w_tmo) begin
                r_rsp_dat <= '0;
                r_rsp_err <= 1'b1;
                r_err     <= (r_err == 8'hFF) ? r_err : r_err + 8'd1;
            end
            // sel/adr/dat keep their last values after the cycle; only cyc/stb/we drop.
            if (w_ack || w_tmo) begin
                r_cyc <= 1'b0;
                r_we  <= 1'b0;
            end else if (r_state == ACTIVE) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign bus.req_ready = r_state == IDLE;
    assign bus.rsp_valid = r_state == RESP;
    assign bus.rsp_dat   = r_rsp_dat;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_we_o  = r_we;
    assign bus.wbm_sel_o = r_sel;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_dat;
    assign bus.busy      = r_state != IDLE;
    assign bus.txn_count = r_txn;
    assign bus.err_count = r_err;
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator: drives wb_cmd_initiator against a registered-ack Wishbone slave and a command-level model.
module tb_wb_cmd_initiator;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_txn = 0;
    int   m_err = 0;
    logic        s_ack = 1'b0;
    logic [31:0] slv_mem [1024] = '{default: '0};
    logic [31:0] ref_mem [1024] = '{default: '0};

    wb_cmd_initiator_if bus();

    wb_cmd_initiator #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Slave decodes 0x3000_0000..0x3000_0EFF; the 0x3000_0Fxx page never acks.
    function automatic logic mapped(input logic [31:0] a);
        return a[31:12] == 20'h30000 && a[11:8] != 4'hF;
    endfunction

    // Registered ack follows cyc&stb by one cycle, so it stays high one cycle past cyc drop.
    always @(posedge clk) begin
        s_ack <= bus.wbm_cyc_o && bus.wbm_stb_o && mapped(bus.wbm_adr_o);
        if (bus.wbm_cyc_o && bus.wbm_stb_o && s_ack && bus.wbm_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.wbm_sel_o[b]) slv_mem[bus.wbm_adr_o[11:2]][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
    end

    assign bus.wbm_ack_i = s_ack;
    assign bus.wbm_dat_i = slv_mem[bus.wbm_adr_o[11:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit hold);
        logic        exp_err;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
        int          n;
        exp_err = !mapped(adr);
        exp_sel = we ? sel : 4'hF;
        exp_dat = (we || exp_err) ? 32'd0 : ref_mem[adr[11:2]];
        if (we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[11:2]][8*b +: 8] = dat[8*b +: 8];
        if (exp_err) m_err = (m_err == 255) ? 255 : m_err + 1;
        else m_txn = (m_txn + 1) % 65536;
        bus.rsp_ready = !hold;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_adr   = adr;
        bus.req_dat   = dat;
        bus.req_sel   = sel;
        tick();
        bus.req_valid = 1'b0;
        bus.req_adr   = $urandom;
        bus.req_dat   = $urandom;
        bus.req_sel   = 4'($urandom);
        bus.req_we    = 1'($urandom);
        check("stale_ack_at_cyc_rise", 32'(bus.wbm_ack_i), 32'd0);
        n = 0;
        while (bus.wbm_cyc_o && n < 40) begin
            check("stb_active", 32'(bus.wbm_stb_o), 32'd1);
            check("we_active", 32'(bus.wbm_we_o), 32'(we));
            check("sel_active", 32'(bus.wbm_sel_o), 32'(exp_sel));
            check("adr_active", bus.wbm_adr_o, adr);
            check("req_ready_active", 32'(bus.req_ready), 32'd0);
            if (we) check("dat_active", bus.wbm_dat_o, dat);
            n++;
            tick();
        end
        check("cyc_cycles", n, exp_err ? 32'd16 : 32'd2);
        check("stb_after", 32'(bus.wbm_stb_o), 32'd0);
        check("we_after", 32'(bus.wbm_we_o), 32'd0);
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_dat", bus.rsp_dat, exp_dat);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        if (hold) begin
            bus.req_valid = 1'b1;
            repeat (5) begin
                tick();
                check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("hold_rsp_dat", bus.rsp_dat, exp_dat);
                check("hold_req_ready", 32'(bus.req_ready), 32'd0);
                check("hold_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        tick();
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("req_ready_back", 32'(bus.req_ready), 32'd1);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("txn_count", 32'(bus.txn_count), 32'(m_txn));
        check("err_count", 32'(bus.err_count), 32'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_dat", bus.rsp_dat, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("rst_we", 32'(bus.wbm_we_o), 32'd0);
        check("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
        check("rst_adr", bus.wbm_adr_o, 32'd0);
        check("rst_dat", bus.wbm_dat_o, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_txn", 32'(bus.txn_count), 32'd0);
        check("rst_err", 32'(bus.err_count), 32'd0);

        txn(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, 1'b0);
        txn(1'b0, 32'h3000_0000, 32'hDEAD_BEEF, 4'h3, 1'b0);
        txn(1'b0, 32'h3000_0FF0, 32'h0, 4'h0, 1'b0);
        txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1);

        // Reset lands in the second ACTIVE cycle of a read, exactly when the slave acks.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_adr   = 32'h3000_0000;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("mid_cyc_before_reset", 32'(bus.wbm_cyc_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_txn = 0;
        m_err = 0;
        check("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_txn", 32'(bus.txn_count), 32'd0);
        check("mid_rst_err", 32'(bus.err_count), 32'd0);
        tick();
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            a = 32'h3000_0000 + 32'($urandom_range(0, 959)) * 4;
            txn(1'b1, a, $urandom, 4'($urandom), 1'b0);
        end
        check("burst_txn_300", 32'(bus.txn_count), 32'd300);
        check("burst_err_0", 32'(bus.err_count), 32'd0);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'h3000_0F00 + 32'($urandom_range(0, 63)) * 4
                                            : 32'h3000_0000 + 32'($urandom_range(0, 959)) * 4;
            txn(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 260; i++) txn(1'($urandom), 32'h3000_0FFC, $urandom, 4'hF, 1'b0);
        check("err_saturated", 32'(bus.err_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
